uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
//
// PURPOSE
//   Shares the single UART transmit path (transmit_data/wr_uart/tx_full) between NUM_REQ byte-stream requesters.
//   Grants whole messages round-robin, prefixes an optional header byte carrying the requester ID, and enforces a
//   maximum message length. Sits between client logic and the UART TX FIFO write port; the UART itself is unchanged.
//
// PARAMETERS
//   NUM_REQ    4        number of requesters, 2..8
//   MAX_LEN    16       max payload bytes per message, 1..255
//   HEADER_EN  1        1: emit header byte before payload; 0: payload only
//   HDR_BASE   8'hA0    header byte = HDR_BASE | {5'b0, id[2:0]}; low 3 bits of HDR_BASE must be 0
//
// PORTS
//   clk            in   1            system clock, all logic on posedge
//   reset_n        in   1            synchronous, active-low reset
//   req_valid      in   NUM_REQ      per-requester byte valid
//   req_data       in   8*NUM_REQ    per-requester byte, requester i on [8*i+:8]
//   req_last       in   NUM_REQ      byte is last of message
//   req_ready      out  NUM_REQ      byte accepted when valid&ready on a clk edge
//   tx_full        in   1            UART TX FIFO full
//   wr_uart        out  1            UART TX FIFO write strobe
//   transmit_data  out  8            byte to UART TX FIFO
//   grant          out  NUM_REQ      one-hot owner of current message, 0 when idle
//   busy           out  1            1 when state != IDLE
//   len_err        out  1            one-cycle pulse: message truncated at MAX_LEN
//
// BEHAVIOUR
//   - Reset (reset_n low at a clk edge): state=IDLE, last_grant=NUM_REQ-1, byte_cnt=0, grant=0, busy=0, len_err=0.
//     wr_uart and req_ready are combinationally forced 0 while reset_n is low. A message cut by reset is abandoned.
//     No resume.
//   - FSM states: IDLE, HEADER, DATA.
//   - IDLE: if any req_valid, pick the first requester set, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
//     Register grant and id.
//     Next state is HEADER if HEADER_EN, else DATA. No byte is written in IDLE (1 cycle arbitration latency).
//   - HEADER: wr_uart = !tx_full; transmit_data = HDR_BASE|id. Advance to DATA on the edge where wr_uart=1.
//     Hold while tx_full.
//   - DATA: req_ready[g] = !tx_full, all other req_ready = 0; wr_uart = req_valid[g] & !tx_full;
//     transmit_data = req_data[g] (combinational pass-through). byte_cnt increments on each accepted byte.
//   - Message end: an accepted byte with req_last[g]=1, or the MAX_LEN-th accepted byte, whichever first.
//     On end: last_grant<=id, grant<=0, byte_cnt<=0, state<=IDLE.
//     If ended by MAX_LEN with req_last=0: len_err=1 for one cycle. Remaining bytes form a new message that competes
//     normally.
//   - Requester valid drop mid-message: the grant is held (no timeout); the arbiter waits.
//   - Non-granted valid inputs are ignored; their req_ready stays 0.
//   - tx_full must never see wr_uart=1 in the same cycle; no byte is lost or duplicated under backpressure.
//   - transmit_data = 8'h00 when wr_uart = 0.
//   - byte_cnt width = $clog2(MAX_LEN+1); no wrap possible.
//
// TESTING
//   1 Single msg: req0 sends 3'h{11,22,33}, last on 33, tx_full=0 -> wr_uart bytes A0,11,22,33 on consecutive cycles
//     after 1-cycle arbitration; grant=0001 during message.
//   2 Round robin: req0..3 all valid with 1-byte messages -> header order A0,A1,A2,A3, then repeat A0.
//     No requester starves.
//   3 Backpressure: tx_full toggled every other cycle during a 5-byte message -> wr_uart never high with tx_full.
//     All 5 bytes appear once, in order.
//   4 Length limit: MAX_LEN=16, req2 streams 20 bytes without last -> A2+16 bytes, len_err pulse.
//     Then, if no others are valid, A2+remaining 4 bytes.
//   5 Reset mid-message: reset_n low for 1 cycle after 2nd payload byte -> wr_uart=0 during reset, busy=0 after.
//     Next grant goes to req0.
//   6 HEADER_EN=0: req1 sends 1 byte 8'h5A -> single write 5A, no header byte.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX FIFO write port between NUM_REQ byte-stream
// requesters. Whole messages are granted round-robin, optionally prefixed with a
// header byte (HDR_BASE | id), and cut at MAX_LEN payload bytes.
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset_n        synchronous active-low reset
//   req_valid      per-requester byte valid
//   req_data       per-requester byte, requester i on [8*i+:8]
//   req_last       per-requester last-byte-of-message flag
//   req_ready      per-requester accept (combinational, only the owner in DATA)
//   tx_full        UART TX FIFO full
//   wr_uart        UART TX FIFO write strobe (combinational)
//   transmit_data  byte to the FIFO, 8'h00 whenever wr_uart is low (combinational)
//   grant          registered one-hot owner of the current message, 0 when idle
//   busy           registered, high while a message is in progress
//   len_err        registered one-cycle pulse when a message is cut at MAX_LEN
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned HEADER_EN = 1,
    parameter logic [7:0]  HDR_BASE  = 8'hA0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_full,
    output logic                 wr_uart,
    output logic [7:0]           transmit_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 len_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   id;
    logic [CNT_W-1:0]   byte_cnt;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_id;
    logic [IDX_W-1:0]   scan_idx;

    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic [7:0]         hdr_byte;

    logic               in_hdr;
    logic               in_data;
    logic               accept;
    logic               msg_end;

    // Round-robin pick: scan from last_grant+1 upward with wrap. The loop runs
    // from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = IDX_W'((32'(last_grant) + 32'd1 + 32'(i)) % NUM_REQ);
            if (req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

    // Owner lane select; grant is one-hot so OR-reduction is a clean mux.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_valid = sel_valid | req_valid[i];
                sel_last  = sel_last | req_last[i];
                sel_data  = sel_data | req_data[8*i +: 8];
            end
        end
    end

    assign hdr_byte = HDR_BASE | 8'(id);
    assign in_hdr   = (state == HEADER);
    assign in_data  = (state == DATA);

    // Write path is combinational so a byte never waits an extra cycle and
    // tx_full gates the strobe in the same cycle; reset forces it quiet.
    assign wr_uart       = reset_n & ~tx_full & (in_hdr | (in_data & sel_valid));
    assign req_ready     = (reset_n & in_data & ~tx_full) ? grant : '0;
    assign transmit_data = !wr_uart ? 8'h00 : (in_hdr ? hdr_byte : sel_data);

    assign accept  = wr_uart & in_data;
    assign msg_end = accept & (sel_last | (byte_cnt == CNT_FINAL));

    // Message FSM with registered grant/busy/len_err.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            id         <= '0;
            byte_cnt   <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            len_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= NUM_REQ'(1) << pick_id;
                        id    <= pick_id;
                        busy  <= 1'b1;
                        state <= (HEADER_EN != 0) ? HEADER : DATA;
                    end
                end
                HEADER: begin
                    if (wr_uart) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (msg_end) begin
                            last_grant <= id;
                            grant      <= '0;
                            byte_cnt   <= '0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                            // Reaching the end without last means the cut was by length.
                            len_err    <= ~sel_last;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned ML = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [NR-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*NR-1:0] req_data;
    logic            tx_full, wr_uart, busy, len_err;
    logic [7:0]      transmit_data;

    logic [NR-1:0]   b_valid, b_last, b_ready, b_grant;
    logic [8*NR-1:0] b_data;
    logic            b_full, b_wr, b_busy, b_len_err;
    logic [7:0]      b_tdata;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML), .HEADER_EN(1), .HDR_BASE(8'hA0)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full), .wr_uart(wr_uart),
        .transmit_data(transmit_data), .grant(grant), .busy(busy), .len_err(len_err)
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML), .HEADER_EN(0), .HDR_BASE(8'hA0)) dut_nohdr (
        .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_data(b_data),
        .req_last(b_last), .req_ready(b_ready), .tx_full(b_full), .wr_uart(b_wr),
        .transmit_data(b_tdata), .grant(b_grant), .busy(b_busy), .len_err(b_len_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } ent_t;

    typedef struct {
        logic [NR-1:0] valid;
        logic [7:0]    data0;
        logic          last0;
        logic          full;
        logic          exp_wr;
        logic [7:0]    exp_data;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_grant;
        logic          exp_busy;
    } vec_t;

    typedef logic [7:0] bq_t[$];

    ent_t       drv_q[NR][$];
    ent_t       mdl_q[NR][$];
    int         cnt_r[NR];
    logic [7:0] obs_q[$];
    int         n_chk, n_pass, n_len_err, exp_len_err;
    bit         model_en, m_hdr;
    int         m_last, m_owner, m_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic last);
        ent_t e;
        e.data = d;
        e.last = last;
        drv_q[r].push_back(e);
        mdl_q[r].push_back(e);
    endtask

    task automatic clear_all();
        for (int r = 0; r < NR; r++) begin
            drv_q[r].delete();
            mdl_q[r].delete();
            cnt_r[r] = 0;
        end
        obs_q.delete();
        n_len_err   = 0;
        exp_len_err = 0;
        m_hdr       = 1'b1;
        m_last      = NR - 1;
        m_owner     = 0;
        m_len       = 0;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        tx_full     = 1'b0;
    endtask

    task automatic do_reset();
        clear_all();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Message-level reference: a header names the first pending requester after
    // the previous owner; its queued bytes follow until last or the length cap.
    task automatic model_byte(input logic [7:0] b);
        ent_t e;
        int   win;
        if (m_hdr) begin
            win = -1;
            for (int i = 1; i <= NR; i++) begin
                int k;
                k = (m_last + i) % NR;
                if (win < 0 && mdl_q[k].size() > 0) win = k;
            end
            if (win < 0) begin
                chk("hdr_with_nothing_pending", 32'(b), 32'hFFFF);
            end else begin
                chk("rand_header", 32'(b), 32'(8'hA0 | 8'(win)));
                m_owner = win;
                m_hdr   = 1'b0;
                m_len   = 0;
            end
        end else if (mdl_q[m_owner].size() == 0) begin
            chk("payload_with_empty_queue", 32'(b), 32'hFFFF);
        end else begin
            e = mdl_q[m_owner].pop_front();
            chk("rand_payload", 32'(b), 32'(e.data));
            m_len++;
            if (e.last || m_len == ML) begin
                m_hdr  = 1'b1;
                m_last = m_owner;
                if (!e.last) exp_len_err++;
            end
        end
    endtask

    // Drives requester queues each cycle, records writes, pops on handshake.
    task automatic run_engine(input int budget, input bit rnd, input int stop_obs);
        int cyc;
        int idle;
        bit done;
        bit empty;
        cyc  = 0;
        idle = 0;
        done = 1'b0;
        while (!done) begin
            for (int r = 0; r < NR; r++) begin
                if (drv_q[r].size() > 0) begin
                    req_valid[r]       = (rnd && cnt_r[r] > 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
                    req_data[8*r +: 8] = drv_q[r][0].data;
                    req_last[r]        = drv_q[r][0].last;
                end else begin
                    req_valid[r]       = 1'b0;
                    req_data[8*r +: 8] = 8'h00;
                    req_last[r]        = 1'b0;
                end
            end
            tx_full = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            @(negedge clk);
            chk("wr_with_full", 32'(wr_uart & tx_full), 32'd0);
            if (wr_uart) begin
                obs_q.push_back(transmit_data);
                if (model_en) model_byte(transmit_data);
            end
            if (len_err) n_len_err++;
            for (int r = 0; r < NR; r++) begin
                if (req_valid[r] && req_ready[r] && drv_q[r].size() > 0) begin
                    ent_t e;
                    e = drv_q[r].pop_front();
                    cnt_r[r]++;
                    if (e.last || cnt_r[r] == ML) cnt_r[r] = 0;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            empty = 1'b1;
            for (int r = 0; r < NR; r++) if (drv_q[r].size() > 0) empty = 1'b0;
            if (empty) idle++;
            if (idle >= 3) done = 1'b1;
            if (stop_obs > 0 && obs_q.size() >= stop_obs) done = 1'b1;
            if (!done && cyc >= budget) begin
                chk("engine_timeout", 32'd1, 32'd0);
                done = 1'b1;
            end
        end
    endtask

    task automatic cmp_stream(input string name, input bq_t exp);
        chk($sformatf("%s_len", name), 32'(obs_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs_q.size(); i++)
            chk($sformatf("%s[%0d]", name, i), 32'(obs_q[i]), 32'(exp[i]));
    endtask

    vec_t vecs[9];
    bq_t  exp;

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        model_en = 1'b0;
        b_valid  = '0;
        b_data   = '0;
        b_last   = '0;
        b_full   = 1'b0;
        do_reset();

        // Single message from req0 with a stall and a non-granted valid on req1.
        //         valid    d0     l0    full  wr    data   ready    grant    busy
        vecs[0] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        vecs[1] = '{4'b0001, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        vecs[2] = '{4'b0011, 8'h11, 1'b0, 1'b0, 1'b1, 8'hA0, 4'b0000, 4'b0001, 1'b1};
        vecs[3] = '{4'b0011, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0001, 1'b1};
        vecs[4] = '{4'b0011, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 4'b0001, 4'b0001, 1'b1};
        vecs[5] = '{4'b0010, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0001, 4'b0001, 1'b1};
        vecs[6] = '{4'b0011, 8'h22, 1'b0, 1'b0, 1'b1, 8'h22, 4'b0001, 4'b0001, 1'b1};
        vecs[7] = '{4'b0001, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 4'b0001, 4'b0001, 1'b1};
        vecs[8] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        for (int v = 0; v < 9; v++) begin
            req_valid = vecs[v].valid;
            req_data  = {8'hEE, 8'hEE, 8'hEE, vecs[v].data0};
            req_last  = {3'b000, vecs[v].last0};
            tx_full   = vecs[v].full;
            @(negedge clk);
            chk($sformatf("vec%0d_wr", v), 32'(wr_uart), 32'(vecs[v].exp_wr));
            chk($sformatf("vec%0d_data", v), 32'(transmit_data), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            @(posedge clk);
            #1;
        end

        // Round robin with one-byte messages from every requester, two rounds.
        do_reset();
        for (int rnd_i = 1; rnd_i <= 2; rnd_i++)
            for (int r = 0; r < NR; r++) add_byte(r, 8'(16 * r + rnd_i), 1'b1);
        run_engine(200, 1'b0, 0);
        exp = '{8'hA0, 8'h01, 8'hA1, 8'h11, 8'hA2, 8'h21, 8'hA3, 8'h31,
                8'hA0, 8'h02, 8'hA1, 8'h12, 8'hA2, 8'h22, 8'hA3, 8'h32};
        cmp_stream("rr", exp);
        chk("rr_len_err", 32'(n_len_err), 32'd0);

        // 20-byte stream from req2: cut after 16, remainder sent as a new message.
        do_reset();
        for (int i = 0; i < 20; i++) add_byte(2, 8'(8'h40 + i), i == 19);
        run_engine(200, 1'b0, 0);
        exp.delete();
        exp.push_back(8'hA2);
        for (int i = 0; i < 16; i++) exp.push_back(8'(8'h40 + i));
        exp.push_back(8'hA2);
        for (int i = 16; i < 20; i++) exp.push_back(8'(8'h40 + i));
        cmp_stream("maxlen", exp);
        chk("maxlen_len_err", 32'(n_len_err), 32'd1);

        // Reset after the second payload byte of a req2 message.
        do_reset();
        for (int i = 0; i < 4; i++) add_byte(2, 8'(8'h61 + i), i == 3);
        run_engine(50, 1'b0, 3);
        exp = '{8'hA2, 8'h61, 8'h62};
        cmp_stream("pre_reset", exp);
        reset_n         = 1'b0;
        req_valid       = 4'b0100;
        req_data[23:16] = 8'h63;
        req_last        = '0;
        tx_full         = 1'b0;
        @(negedge clk);
        chk("rst_wr_forced", 32'(wr_uart), 32'd0);
        chk("rst_ready_forced", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_all();
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_grant", 32'(grant), 32'd0);
        @(posedge clk);
        #1;
        add_byte(0, 8'h71, 1'b1);
        add_byte(3, 8'h72, 1'b1);
        run_engine(100, 1'b0, 0);
        exp = '{8'hA0, 8'h71, 8'hA3, 8'h72};
        cmp_stream("post_rst", exp);

        // Header disabled: a single byte from req1 goes out alone.
        b_valid      = 4'b0010;
        b_data[15:8] = 8'h5A;
        b_last       = 4'b0010;
        @(negedge clk);
        chk("nohdr_arb_wr", 32'(b_wr), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("nohdr_wr", 32'(b_wr), 32'd1);
        chk("nohdr_data", 32'(b_tdata), 32'h5A);
        chk("nohdr_ready", 32'(b_ready), 32'b0010);
        chk("nohdr_grant", 32'(b_grant), 32'b0010);
        @(posedge clk);
        #1;
        b_valid = '0;
        b_last  = '0;
        @(negedge clk);
        chk("nohdr_after_wr", 32'(b_wr), 32'd0);
        chk("nohdr_after_data", 32'(b_tdata), 32'h00);
        chk("nohdr_after_busy", 32'(b_busy), 32'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with backpressure and owner valid gaps.
        do_reset();
        for (int r = 0; r < NR; r++)
            for (int m = 0; m < 3; m++) begin
                int len;
                len = $urandom_range(1, 22);
                for (int i = 0; i < len; i++) add_byte(r, 8'($urandom), i == len - 1);
            end
        model_en = 1'b1;
        run_engine(20000, 1'b1, 0);
        model_en = 1'b0;
        begin
            int left;
            left = 0;
            for (int r = 0; r < NR; r++) left += mdl_q[r].size();
            chk("rand_bytes_left", 32'(left), 32'd0);
        end
        chk("rand_msg_closed", 32'(m_hdr), 32'd1);
        chk("rand_len_err_count", 32'(n_len_err), 32'(exp_len_err));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
